// File: rtl/uart_pkg.sv
// UART receiver shared definitions.
// FSM state codes, parity modes and default oversampling ratio.
package uart_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int OVS_DEF = 16;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous input.
// Resets to 1 so an idle-high line reads idle out of reset.
module uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled deserialiser with holding
// register, valid/ack handshake and one-cycle error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int OVS       = OVS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVS);
  localparam logic [TW-1:0] TC_MID = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] TC_END = TW'(OVS - 1);
  localparam logic [3:0]    BC_END = 4'(DATA_BITS - 1);

  logic rx_s;
  logic rx_prev_q;

  uart_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 ovr_q, ovr_d;

  logic start_edge;
  logic samp_mid;
  logic samp_end;
  logic load;

  assign start_edge = rx_prev_q & ~rx_s;
  assign samp_mid   = tick && (tick_cnt_q == TC_MID);
  assign samp_end   = tick && (tick_cnt_q == TC_END);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    data_d     = data_q;
    valid_d    = valid_q & ~rx_ack;
    ferr_d     = 1'b0;
    perr_d     = 1'b0;
    ovr_d      = 1'b0;
    load       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d    = S_START;
          tick_cnt_d = '0;
        end
      end
      S_START: begin
        if (samp_mid) begin
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          par_bad_d  = 1'b0;
          state_d    = rx_s ? S_IDLE : S_DATA;
        end else if (tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (samp_end) begin
          tick_cnt_d = '0;
          shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BC_END)
            state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
        end else if (tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (samp_end) begin
          tick_cnt_d = '0;
          // XOR of data and parity bit is 1 only for odd parity
          par_bad_d  = (^shift_q) ^ rx_s ^ (PARITY == PAR_ODD);
          state_d    = S_STOP;
        end else if (tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (samp_end) begin
          tick_cnt_d = '0;
          state_d    = S_IDLE;
          if (!rx_s)          ferr_d = 1'b1;
          else if (par_bad_q) perr_d = 1'b1;
          else                load   = 1'b1;
        end else if (tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      ovr_d   = valid_q & ~rx_ack;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev_q  <= 1'b1;
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_bad_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_prev_q  <= rx_s;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_bad_q  <= par_bad_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: 8N1 and 8O1 instances, frame-level reference
// model feeding a scoreboard checked by per-instance monitors.
module tb_uart_rx;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick;
  logic rx0 = 1'b1, rx1 = 1'b1;
  logic ack0 = 1'b0, ack1 = 1'b0;
  logic [7:0] data0, data1;
  logic valid0, valid1, fe0, fe1, pe0, pe1, ov0, ov1;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // one tick every 4 clocks, sampled on posedges where cyc%4==0
  assign tick = (cyc % 4 == 3);

  uart_rx #(.DATA_BITS(8), .PARITY(PAR_NONE), .OVS(16)) u0 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx0),
    .rx_data(data0), .rx_valid(valid0), .rx_ack(ack0),
    .frame_err(fe0), .parity_err(pe0), .overrun(ov0)
  );

  uart_rx #(.DATA_BITS(8), .PARITY(PAR_ODD), .OVS(16)) u1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx1),
    .rx_data(data1), .rx_valid(valid1), .rx_ack(ack1),
    .frame_err(fe1), .parity_err(pe1), .overrun(ov1)
  );

  typedef struct {
    int         kind;
    logic [7:0] data;
    bit         ov;
    int         q;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  bit   valid_m [2];

  // 0 good, 1 framing error, 2 parity error
  function automatic int outcome(input logic [7:0] d, input int pm,
                                 input bit pbit, input bit stop);
    int ones;
    if (!stop) return 1;
    ones = $countones(d) + int'(pbit);
    if (pm == PAR_EVEN && (ones % 2) != 0) return 2;
    if (pm == PAR_ODD && (ones % 2) != 1) return 2;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic set_rx(input int d, input logic v);
    if (d == 0) rx0 = v;
    else        rx1 = v;
  endtask

  task automatic set_ack(input int d, input logic v);
    if (d == 0) ack0 = v;
    else        ack1 = v;
  endtask

  task automatic ack_now(input int d);
    @(negedge clk);
    set_ack(d, 1'b1);
    @(negedge clk);
    set_ack(d, 1'b0);
    valid_m[d] = 1'b0;
  endtask

  task automatic ack_pulse(input int d, input int q);
    while (cyc < q - 1) @(negedge clk);
    set_ack(d, 1'b1);
    @(negedge clk);
    set_ack(d, 1'b0);
  endtask

  task automatic align();
    do @(negedge clk); while (cyc % 4 != 0);
  endtask

  // Start bit begins right after tick-posedge p; the start midpoint is
  // the 8th tick (p+32) and each later bit centre is 64 clocks on.
  task automatic send_frame(input int d, input logic [7:0] data,
                            input bit pbit, input bit stop,
                            input bit ack_same, input int low_ticks);
    int   pm;
    int   n;
    int   p;
    exp_t e;
    bit   line[$];
    pm = (d == 0) ? PAR_NONE : PAR_ODD;
    n  = 8 + ((pm != PAR_NONE) ? 1 : 0);
    line.push_back(1'b0);
    for (int i = 0; i < 8; i++) line.push_back(data[i]);
    if (pm != PAR_NONE) line.push_back(pbit);
    line.push_back(stop);
    align();
    p      = cyc;
    e.kind = outcome(data, pm, pbit, stop);
    e.data = data;
    e.q    = p + 32 + 64 * (n + 1);
    e.ov   = (e.kind == 0) && valid_m[d] && !ack_same;
    if (e.kind == 0) valid_m[d] = 1'b1;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    if (ack_same) begin
      fork
        ack_pulse(d, e.q);
      join_none
    end
    foreach (line[i]) begin
      set_rx(d, line[i]);
      repeat (64) @(negedge clk);
    end
    if (!stop) begin
      repeat (4 * low_ticks) @(negedge clk);
      set_rx(d, 1'b1);
      repeat (64) @(negedge clk);
    end
  endtask

  task automatic mon(input int d, input logic [7:0] dat, input logic v,
                     input logic fe, input logic pe, input logic ov,
                     input logic [7:0] pdat, input logic pv);
    bit   ev;
    bit   ok;
    exp_t e;
    ev = fe || pe || ov || (v && !pv) || (v && dat != pdat);
    if (!ev) return;
    vectors++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      miscompares++;
      $display("FAIL unexpected_event dut%0d cyc=%0d: fe=%b pe=%b ov=%b v=%b data=%h, expected no event",
               d, cyc, fe, pe, ov, v, dat);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    case (e.kind)
      0:       ok = v && dat == e.data && !fe && !pe && ov == e.ov;
      1:       ok = fe && !pe && !ov && v == pv && dat == pdat;
      default: ok = pe && !fe && !ov && v == pv && dat == pdat;
    endcase
    ok = ok && (cyc == e.q);
    if (!ok) begin
      miscompares++;
      $display("FAIL frame dut%0d: got cyc=%0d v=%b data=%h fe=%b pe=%b ov=%b, expected cyc=%0d kind=%0d data=%h ov=%b",
               d, cyc, v, dat, fe, pe, ov, e.q, e.kind, e.data, e.ov);
    end
  endtask

  logic [7:0] pd0 = '0, pd1 = '0;
  logic       pv0 = 1'b0, pv1 = 1'b0;

  always @(negedge clk) begin
    if (rst_n) mon(0, data0, valid0, fe0, pe0, ov0, pd0, pv0);
    pd0 <= data0;
    pv0 <= valid0;
  end

  always @(negedge clk) begin
    if (rst_n) mon(1, data1, valid1, fe1, pe1, ov1, pd1, pv1);
    pd1 <= data1;
    pv1 <= valid1;
  end

  initial begin
    logic [7:0] d8;
    bit         pb;
    bit         st;
    int         dsel;

    repeat (3) @(negedge clk);
    chk("reset_u0", {valid0, fe0, pe0, ov0, data0}, 32'h0);
    chk("reset_u1", {valid1, fe1, pe1, ov1, data1}, 32'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    ack_now(0);
    chk("ack_idle_ignored", {31'd0, valid0}, 32'd0);

    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b0, 0);
    chk("hold_a5", {23'd0, valid0, data0}, {23'd0, 1'b1, 8'hA5});
    ack_now(0);
    @(negedge clk);
    chk("ack_clears", {31'd0, valid0}, 32'd0);

    align();
    rx0 = 1'b0;
    repeat (12) @(negedge clk);
    rx0 = 1'b1;
    repeat (128) @(negedge clk);
    chk("glitch_no_valid", {31'd0, valid0}, 32'd0);
    send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b0, 0);
    ack_now(0);

    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, 40);
    chk("ferr_no_load", {31'd0, valid0}, 32'd0);
    send_frame(0, 8'h12, 1'b0, 1'b1, 1'b0, 0);
    ack_now(0);

    send_frame(1, 8'h07, 1'b0, 1'b1, 1'b0, 0);
    chk("odd_par_good", {23'd0, valid1, data1}, {23'd0, 1'b1, 8'h07});
    ack_now(1);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b0, 0);
    chk("par_err_no_load", {31'd0, valid1}, 32'd0);

    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b0, 0);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1'b0, 0);
    chk("overrun_data", {24'd0, data0}, 32'h22);
    ack_now(0);
    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b0, 0);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1, 0);
    chk("ack_same_cycle", {23'd0, valid0, data0}, {23'd0, 1'b1, 8'h22});
    ack_now(0);

    send_frame(0, 8'h44, 1'b0, 1'b1, 1'b0, 0);
    align();
    rx0 = 1'b0;
    repeat (64) @(negedge clk);
    rx0 = 1'b1;
    repeat (64 * 4 + 20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midframe_reset", {valid0, fe0, pe0, ov0, data0}, 32'h0);
    valid_m[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (64 * 6) @(negedge clk);
    chk("after_reset_idle", {31'd0, valid0}, 32'd0);
    send_frame(0, 8'h81, 1'b0, 1'b1, 1'b0, 0);
    chk("after_reset_81", {23'd0, valid0, data0}, {23'd0, 1'b1, 8'h81});
    ack_now(0);

    for (int k = 0; k < 30; k++) begin
      dsel = int'($urandom_range(0, 1));
      d8   = 8'($urandom);
      st   = ($urandom_range(0, 5) != 0);
      pb   = ~(^d8);
      if ($urandom_range(0, 3) == 0) pb = ~pb;
      send_frame(dsel, d8, pb, st, 1'b0, int'($urandom_range(0, 8)));
      if ($urandom_range(0, 1) == 1) ack_now(dsel);
    end

    repeat (100) @(negedge clk);
    chk("sb_empty_u0", q0.size(), 32'd0);
    chk("sb_empty_u1", q1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receive stage; consumes the 16x oversampling tick from the baud rate generator and deserialises the asynchronous rx line.
- Synchronises rx to clk, validates the start bit at its midpoint, samples data/parity/stop at bit centres (LSB first).
- Presents each good character in a holding register with a valid/ack handshake to the downstream consumer (FIFO or CPU register bank).

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..8
PARITY, 0, 0 = none, 1 = even, 2 = odd
OVS, 16, ticks per bit; must match generator oversampling

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tick  input  1  single-cycle oversampling strobe from baud rate generator
rx  input  1  serial line, idle high, asynchronous to clk
rx_data  output  DATA_BITS  received character, held until next good frame
rx_valid  output  1  holding register full
rx_ack  input  1  consumer accepts rx_data; clears rx_valid
frame_err  output  1  one-clk pulse: stop bit sampled low
parity_err  output  1  one-clk pulse: parity mismatch
overrun  output  1  one-clk pulse: good frame arrived while rx_valid=1 and no ack

Behaviour:
- Reset (async, rst_n=0): state IDLE; sync flops = 1; tick_cnt, bit_cnt, shift reg = 0; rx_data=0; rx_valid, frame_err, parity_err, overrun = 0.
- Input sync: 2-flop synchroniser, then one delay flop for edge detect; rx_s = synchronised line.
- Start edge = rx_s falling (previous 1, current 0). A line held low never retriggers.
- tick_cnt advances only on clk cycles with tick=1. All sampling happens on tick cycles.
- IDLE: on start edge -> START, tick_cnt=0.
- START: on the tick where tick_cnt==OVS/2-1, sample rx_s. 0 -> DATA, tick_cnt=0, bit_cnt=0. 1 -> glitch, back to IDLE with no flag.
- DATA: on the tick where tick_cnt==OVS-1, shift rx_s into the MSB of the shift reg (right shift, so LSB first on the line), bit_cnt++, tick_cnt=0. After DATA_BITS samples -> PARITY if PARITY!=0, else STOP.
- PARITY: sample at tick_cnt==OVS-1. Even: XOR(data, bit) must be 0. Odd: must be 1. Keep the mismatch in an internal flag; go to STOP.
- STOP: sample at tick_cnt==OVS-1, i.e. at stop-bit centre, then -> IDLE immediately. This permits back-to-back frames with one stop bit.
  - Stop = 0: frame_err pulse; no load.
  - Stop = 1 with parity mismatch: parity_err pulse; no load.
  - Stop = 1, parity good: load rx_data, set rx_valid.
- Frame completion outputs appear on the clk cycle after the stop-sampling tick.
- Handshake:
  - rx_ack with rx_valid=1 clears rx_valid next cycle.
  - rx_ack with rx_valid=0 is ignored.
  - New good frame and rx_ack in the same cycle: load, rx_valid stays 1, no overrun.
  - New good frame with rx_valid=1 and no ack: overwrite rx_data, rx_valid stays 1, overrun pulse.
- Error pulses and overrun last exactly one clk. frame_err and parity_err are mutually exclusive; frame_err has priority.
- rst_n asserted mid-frame: immediate return to reset values; the partial frame is discarded. After release, reception waits for a fresh falling edge.
- tick arriving in the same cycle as the start edge does not count; tick_cnt starts from the next tick.

Decomposition:
- Package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP), PARITY encoding constants (PAR_NONE/EVEN/ODD), OVS default.
- One natural sub-module: uart_sync, a 2-flop synchroniser with reset value 1, reused later by the transmitter's CTS input. The rest is a single module.

Test Plan:
- Tick every 4 clk, 8N1, send 0xA5 (line sequence 0,1,0,1,0,0,1,0,1,1) -> rx_data=0xA5, rx_valid=1 one clk after stop-centre tick; no error pulses.
- rx low for 3 ticks then high -> START rejects; state back to IDLE; rx_valid=0; no error pulses; next frame 0x3C received correctly.
- Send 0x55 with stop bit forced 0 and line held low 40 ticks -> one frame_err pulse; rx_valid unchanged; no new start until line returns high; then 0x12 received.
- PARITY=2 (odd), send 0x07 with parity bit 0 -> rx_valid=1, data 0x07. Resend with parity bit 1 -> parity_err pulse, no load.
- Two back-to-back frames 0x11 then 0x22, no rx_ack -> rx_data=0x22, overrun pulse once. Repeat with rx_ack asserted on the second completion cycle -> no overrun.
- rst_n pulsed low during DATA bit 4 of 0xFF -> all outputs 0 immediately. After release, an ensuing clean 0x81 frame gives rx_data=0x81.
